// File: rtl/loop_count_scheduler.sv
// Shares one bounded up-counter (0..limit, then stop) between two requesters.
// A round-robin arbiter picks the owner, and the owner receives a one-cycle done pulse when its count completes.
module loop_count_scheduler #(
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [N:0] limit0,
  input  logic       req1,
  input  logic [N:0] limit1,
  output logic       grant0,
  output logic       grant1,
  output logic       done0,
  output logic       done1,
  output logic [N:0] count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       rr_last, rr_last_nxt;
  logic [N:0] limit_reg, limit_nxt;
  logic [N:0] count_nxt;
  logic       grant0_nxt, grant1_nxt, done0_nxt, done1_nxt, busy_nxt;
  logic       owner_req, winner;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    state_nxt   = state;
    owner_nxt   = owner;
    rr_last_nxt = rr_last;
    limit_nxt   = limit_reg;
    count_nxt   = count;
    grant0_nxt  = grant0;
    grant1_nxt  = grant1;
    done0_nxt   = 1'b0;
    done1_nxt   = 1'b0;
    busy_nxt    = busy;
    owner_req   = owner ? req1 : req0;
    // When both requesters are high, the one that did not win last time gets the counter.
    winner      = (req0 && req1) ? ~rr_last : req1;

    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt   = COUNT;
          owner_nxt   = winner;
          rr_last_nxt = winner;
          limit_nxt   = winner ? limit1 : limit0;
          count_nxt   = '0;
          grant0_nxt  = ~winner;
          grant1_nxt  = winner;
          busy_nxt    = 1'b1;
        end
      end
      COUNT: begin
        if (!owner_req) begin
          // An abort returns to IDLE without a done pulse. The arbitration history is kept.
          state_nxt  = IDLE;
          count_nxt  = '0;
          grant0_nxt = 1'b0;
          grant1_nxt = 1'b0;
          busy_nxt   = 1'b0;
        end else if (count == limit_reg) begin
          state_nxt = DONE;
          done0_nxt = ~owner;
          done1_nxt = owner;
        end else begin
          count_nxt = count + (N+1)'(1);
        end
      end
      DONE: begin
        state_nxt  = IDLE;
        count_nxt  = '0;
        grant0_nxt = 1'b0;
        grant1_nxt = 1'b0;
        busy_nxt   = 1'b0;
      end
      default: begin
        state_nxt  = IDLE;
        count_nxt  = '0;
        grant0_nxt = 1'b0;
        grant1_nxt = 1'b0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rr_last   <= 1'b1;
      limit_reg <= '0;
      count     <= '0;
      grant0    <= 1'b0;
      grant1    <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_last   <= rr_last_nxt;
      limit_reg <= limit_nxt;
      count     <= count_nxt;
      grant0    <= grant0_nxt;
      grant1    <= grant1_nxt;
      done0     <= done0_nxt;
      done1     <= done1_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_loop_count_scheduler.sv
// Bench for loop_count_scheduler. Each grant expands into a planned queue of per-cycle outputs,
// and the bench compares the DUT against that plan on every cycle.
module tb_loop_count_scheduler;

  logic       clk = 1'b0;
  logic       reset, req0, req1;
  logic [3:0] limit0, limit1;
  logic       grant0, grant1, done0, done1, busy;
  logic [3:0] count;

  always #5 clk = ~clk;

  loop_count_scheduler dut (
    .clk(clk), .reset(reset),
    .req0(req0), .limit0(limit0), .req1(req1), .limit1(limit1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .count(count), .busy(busy)
  );

  typedef struct packed {
    logic       g0, g1, d0, d1;
    logic [3:0] cnt;
    logic       busy;
  } obs_t;

  obs_t exp_s;
  obs_t plan[$];
  logic rr;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  // The reference model works per transaction: a grant with limit L plans the counts 1..L
  // and then a done cycle. Once the plan is empty, the next cycle is idle.
  task automatic model_step(input logic rst, input logic r0, input logic [3:0] l0,
                            input logic r1, input logic [3:0] l1);
    logic       w;
    logic [3:0] lim;
    obs_t       e;
    if (rst) begin
      plan.delete();
      exp_s = '0;
      rr    = 1'b1;
    end else if (exp_s.busy && !exp_s.d0 && !exp_s.d1 && !(exp_s.g1 ? r1 : r0)) begin
      plan.delete();
      exp_s = '0;
    end else if (plan.size() > 0) begin
      exp_s = plan.pop_front();
    end else if (exp_s.busy) begin
      exp_s = '0;
    end else if (r0 || r1) begin
      w   = (r0 && r1) ? ~rr : r1;
      rr  = w;
      lim = w ? l1 : l0;
      exp_s      = '0;
      exp_s.g0   = ~w;
      exp_s.g1   = w;
      exp_s.busy = 1'b1;
      for (int i = 1; i <= int'(lim); i++) begin
        e     = exp_s;
        e.cnt = i[3:0];
        plan.push_back(e);
      end
      e     = exp_s;
      e.cnt = lim;
      e.d0  = ~w;
      e.d1  = w;
      plan.push_back(e);
    end
  endtask

  task automatic cycle(input logic rst, input logic r0, input logic [3:0] l0,
                       input logic r1, input logic [3:0] l1);
    reset  = rst;
    req0   = r0;
    limit0 = l0;
    req1   = r1;
    limit1 = l1;
    model_step(rst, r0, l0, r1, l1);
    @(negedge clk);
    check("grant0", 32'(grant0), 32'(exp_s.g0));
    check("grant1", 32'(grant1), 32'(exp_s.g1));
    check("done0",  32'(done0),  32'(exp_s.d0));
    check("done1",  32'(done1),  32'(exp_s.d1));
    check("count",  32'(count),  32'(exp_s.cnt));
    check("busy",   32'(busy),   32'(exp_s.busy));
    check("grant_onehot", 32'(grant0 & grant1), 32'd0);
    check("done_onehot",  32'(done0 & done1),   32'd0);
  endtask

  logic r0, r1, rst;
  logic [3:0] l0, l1;

  initial begin
    exp_s  = '0;
    rr     = 1'b1;
    reset  = 1'b1;
    req0   = 1'b0;
    req1   = 1'b0;
    limit0 = '0;
    limit1 = '0;
    @(negedge clk);

    // Single request with limit 3.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (6) cycle(0, 1, 3, 0, 0);
    repeat (2) cycle(0, 0, 3, 0, 0);

    // Both requesters held high from reset, so the grants alternate.
    cycle(1, 1, 2, 1, 5);
    repeat (30) cycle(0, 1, 2, 1, 5);
    cycle(1, 0, 0, 0, 0);

    // Limit 0 on requester 1.
    repeat (3) cycle(0, 0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);

    // Full-range limit, so the count must not wrap.
    repeat (18) cycle(0, 1, 15, 0, 0);
    repeat (2) cycle(0, 0, 15, 0, 0);

    // Abort when the count reaches 2.
    for (int i = 0; i < 20 && !(exp_s.busy && exp_s.cnt == 4'd2); i++) cycle(0, 1, 6, 0, 0);
    repeat (3) cycle(0, 0, 6, 0, 0);

    // The limit changes mid-count, then reset arrives at count 3.
    cycle(0, 1, 4, 0, 0);
    for (int i = 0; i < 20 && !(exp_s.busy && exp_s.cnt == 4'd3); i++) cycle(0, 1, 9, 0, 0);
    cycle(1, 1, 9, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Randomised traffic with sticky requests, occasional aborts and occasional resets.
    r0 = 0;
    r1 = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(199) == 0);
      if (r0) begin
        if (exp_s.d0 && $urandom_range(1) == 1) r0 = 0;
        else if (exp_s.g0 && !exp_s.d0 && $urandom_range(39) == 0) r0 = 0;
      end else r0 = ($urandom_range(3) == 0);
      if (r1) begin
        if (exp_s.d1 && $urandom_range(1) == 1) r1 = 0;
        else if (exp_s.g1 && !exp_s.d1 && $urandom_range(39) == 0) r1 = 0;
      end else r1 = ($urandom_range(3) == 0);
      l0 = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
      l1 = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
      cycle(rst, r0, l0, r1, l1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
